// File: rtl/axi4_write_burster.sv
// axi4_write_burster: turns one burst request plus a write-data stream into an AXI4 INCR write burst.
// Ports:
//   clock, reset (async active-low)
//   req_valid/req_ready, req_addr, req_len      burst request (len = beats - 1)
//   data_valid/data_ready, data_bits            write-data stream
//   aw_valid/aw_ready, aw_addr/size/len/burst   AXI write-address channel
//   w_valid/w_ready, w_data, w_strb, w_last     AXI write-data channel
//   b_valid/b_ready, b_resp                     AXI write-response channel
//   done_valid, done_resp                       one-cycle completion pulse and status
//   busy                                        high whenever not IDLE
// Build option: define AXI_WB_4K_CHECK_EN to reject bursts crossing a 4 KB page;
// a rejected burst has its data drained and completes with SLVERR (2'b10).
module axi4_write_burster #(
    parameter int ADDR_BITS = 32,
    parameter int SIZE_BITS = 3,
    parameter int LEN_BITS  = 8,
    parameter int DATA_BITS = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_BITS-1:0]   req_addr,
    input  logic [LEN_BITS-1:0]    req_len,
    input  logic                   data_valid,
    output logic                   data_ready,
    input  logic [DATA_BITS-1:0]   data_bits,
    output logic                   aw_valid,
    input  logic                   aw_ready,
    output logic [ADDR_BITS-1:0]   aw_addr,
    output logic [SIZE_BITS-1:0]   aw_size,
    output logic [LEN_BITS-1:0]    aw_len,
    output logic [1:0]             aw_burst,
    output logic                   w_valid,
    input  logic                   w_ready,
    output logic [DATA_BITS-1:0]   w_data,
    output logic [DATA_BITS/8-1:0] w_strb,
    output logic                   w_last,
    input  logic                   b_valid,
    output logic                   b_ready,
    input  logic [1:0]             b_resp,
    output logic                   done_valid,
    output logic [1:0]             done_resp,
    output logic                   busy
);
    localparam int BYTES = DATA_BITS / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam logic [LEN_BITS:0] ONE = 1;

`ifdef AXI_WB_4K_CHECK_EN
    typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DRAIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
`endif

    state_t                state, state_nxt;
    logic [ADDR_BITS-1:0]  addr_q, aligned;
    logic [LEN_BITS-1:0]   len_q;
    logic [LEN_BITS:0]     cnt;
    logic                  req_fire, aw_fire, w_fire, data_fire, b_fire;
    logic                  last_beat, cnt_ok, w_load, go_drain;

    assign aligned   = req_addr & ~ADDR_BITS'(BYTES - 1);
    assign req_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign b_ready   = state == RESP;
    assign aw_addr   = addr_q;
    assign aw_len    = len_q;
    assign aw_size   = SIZE_BITS'(OFF);
    assign aw_burst  = 2'b01;
    assign w_strb    = {BYTES{w_valid}};
    // The counter is one bit wider than len so a 2^LEN_BITS-beat burst cannot wrap.
    assign last_beat = cnt == {1'b0, len_q};
    assign cnt_ok    = cnt <= {1'b0, len_q};
    assign req_fire  = req_valid && req_ready;
    assign aw_fire   = aw_valid && aw_ready;
    assign w_fire    = w_valid && w_ready;
    assign data_fire = data_valid && data_ready;
    assign b_fire    = b_valid && b_ready;
    assign w_load    = data_fire && state == DATA;

`ifdef AXI_WB_4K_CHECK_EN
    logic [31:0] span;
    assign span       = 32'(aligned[11:0]) + (32'(req_len) + 32'd1) * 32'(BYTES);
    assign go_drain   = span > 32'd4096;
    // Draining swallows the stream without touching the W channel.
    assign data_ready = cnt_ok && ((state == DATA && (!w_valid || w_ready)) || state == DRAIN);
`else
    assign go_drain   = 1'b0;
    assign data_ready = cnt_ok && state == DATA && (!w_valid || w_ready);
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
`ifdef AXI_WB_4K_CHECK_EN
            IDLE:    if (req_fire) state_nxt = go_drain ? DRAIN : ADDR;
            DRAIN:   if (data_fire && last_beat) state_nxt = IDLE;
`else
            IDLE:    if (req_fire) state_nxt = ADDR;
`endif
            ADDR:    if (aw_fire) state_nxt = DATA;
            DATA:    if (w_fire && w_last) state_nxt = RESP;
            RESP:    if (b_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            len_q      <= '0;
            cnt        <= '0;
            aw_valid   <= 1'b0;
            w_valid    <= 1'b0;
            w_data     <= '0;
            w_last     <= 1'b0;
            done_valid <= 1'b0;
            done_resp  <= 2'b00;
        end else begin
            done_valid <= 1'b0;
            if (req_fire) begin
                addr_q   <= aligned;
                len_q    <= req_len;
                cnt      <= '0;
                aw_valid <= !go_drain;
            end
            if (aw_fire) aw_valid <= 1'b0;
            if (data_fire) cnt <= cnt + ONE;
            // A load in the same cycle as a W handshake refills the buffer with no bubble.
            if (w_load) begin
                w_data  <= data_bits;
                w_valid <= 1'b1;
                w_last  <= last_beat;
            end else if (w_fire) begin
                w_valid <= 1'b0;
                w_last  <= 1'b0;
            end
            if (b_fire) begin
                done_valid <= 1'b1;
                done_resp  <= b_resp;
            end
`ifdef AXI_WB_4K_CHECK_EN
            if (state == DRAIN && data_fire && last_beat) begin
                done_valid <= 1'b1;
                done_resp  <= 2'b10;
            end
`endif
        end
    end
endmodule

// File: tb/tb_axi4_write_burster.sv
// tb_axi4_write_burster: randomized self-checking bench for axi4_write_burster (DATA_BITS=64).
module tb_axi4_write_burster;
    logic        clock = 0, reset = 0;
    logic        req_valid = 0, req_ready;
    logic [31:0] req_addr = 0;
    logic [7:0]  req_len = 0;
    logic        data_valid = 0, data_ready;
    logic [63:0] data_bits = 0;
    logic        aw_valid, aw_ready = 0;
    logic [31:0] aw_addr;
    logic [2:0]  aw_size;
    logic [7:0]  aw_len;
    logic [1:0]  aw_burst;
    logic        w_valid, w_ready = 0;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        w_last;
    logic        b_valid = 0, b_ready;
    logic [1:0]  b_resp = 0;
    logic        done_valid;
    logic [1:0]  done_resp;
    logic        busy;
    int          passed = 0, total = 0;

    axi4_write_burster dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .data_valid(data_valid), .data_ready(data_ready), .data_bits(data_bits),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_size(aw_size),
        .aw_len(aw_len), .aw_burst(aw_burst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
        .done_valid(done_valid), .done_resp(done_resp), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // mode 0: aw_ready/w_ready tied high; 1: w_ready toggles each cycle; 2: both random.
    task automatic burst(input logic [31:0] addr, input int len, input int mode, input logic [1:0] bresp);
        logic [63:0] src[$];
        logic [63:0] got[$];
        logic [63:0] pd = 0;
        logic [31:0] aligned;
        logic [1:0]  dresp = 0;
        bit          drain = 0, pw = 0, pa = 0, stable_ok = 1, last_ok = 1, data_ok = 1;
        int          lasts = 0, aws = 0, dones = 0, src_i = 0, cyc = 0;
        aligned = addr & ~32'h7;
`ifdef AXI_WB_4K_CHECK_EN
        drain = ({20'b0, aligned[11:0]} + (len + 1) * 8) > 4096;
`endif
        for (int i = 0; i <= len; i++) src.push_back({$urandom, $urandom});
        @(negedge clock);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1; req_addr = addr; req_len = 8'(len);
        @(negedge clock);
        req_valid = 0;
        chk("busy_after_req", busy, 1);
        while (dones == 0 && cyc < 5000) begin
            if (cyc > 0) @(negedge clock);
            cyc++;
            if (done_valid) begin dones++; dresp = done_resp; end
            if (pw && (!w_valid || w_data !== pd)) stable_ok = 0;
            if (pa && !aw_valid) stable_ok = 0;
            aw_ready   = mode == 0 ? 1'b1 : 1'($urandom_range(0, 1));
            w_ready    = mode == 0 ? 1'b1 : mode == 1 ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
            data_valid = src_i <= len && $urandom_range(0, 3) != 0;
            data_bits  = src_i <= len ? src[src_i] : 64'd0;
            b_valid    = 1'($urandom_range(0, 1));
            b_resp     = bresp;
            #1;
            if (aw_valid && aw_ready) begin
                aws++;
                chk("aw_addr", aw_addr, aligned);
                chk("aw_len", aw_len, len);
                chk("aw_size", aw_size, 3);
                chk("aw_burst", aw_burst, 1);
            end
            pw = w_valid && !w_ready; pd = w_data; pa = aw_valid && !aw_ready;
            if (w_valid && w_ready) begin
                got.push_back(w_data);
                if (w_strb !== 8'hFF) data_ok = 0;
                if (w_last) lasts++;
                if (w_last !== (got.size() == len + 1)) last_ok = 0;
            end
            if (data_valid && data_ready) src_i++;
        end
        b_valid = 0; data_valid = 0;
        chk("done_seen", dones, 1);
        chk("done_resp", dresp, drain ? 2'b10 : bresp);
        chk("aw_count", aws, drain ? 0 : 1);
        chk("beat_count", got.size(), drain ? 0 : len + 1);
        chk("consumed", src_i, len + 1);
        if (!drain) for (int i = 0; i < got.size() && i <= len; i++) if (got[i] !== src[i]) data_ok = 0;
        chk("data_order", data_ok, 1);
        chk("last_count", lasts, drain ? 0 : 1);
        chk("last_position", last_ok, 1);
        chk("valid_stable", stable_ok, 1);
        @(negedge clock);
        chk("done_one_cycle", done_valid, 0);
        chk("idle_after", busy, 0);
    endtask

    initial begin
        int n, cyc;
        #1;
        chk("rst_aw_valid", aw_valid, 0);
        chk("rst_w_valid", w_valid, 0);
        chk("rst_done", done_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 1);
        #20 reset = 1;
        burst(32'h1000, 3, 0, 2'b00);
        burst(32'h2004, 0, 0, 2'b00);
        burst(32'h3000, 7, 1, 2'b01);
        // Reset in the middle of a burst.
        @(negedge clock);
        req_valid = 1; req_addr = 32'h6000; req_len = 8'd7;
        aw_ready = 1; w_ready = 1; data_valid = 1; data_bits = 64'hA5A5_0000_1234_5678;
        @(negedge clock);
        req_valid = 0;
        n = 0; cyc = 0;
        while (n < 2 && cyc < 100) begin
            @(negedge clock); cyc++;
            #1 if (w_valid && w_ready) n++;
        end
        chk("mid_burst_reached", n, 2);
        @(posedge clock); #2 reset = 0;
        #1;
        chk("mid_rst_aw_valid", aw_valid, 0);
        chk("mid_rst_w_valid", w_valid, 0);
        chk("mid_rst_w_last", w_last, 0);
        chk("mid_rst_w_data", w_data, 0);
        chk("mid_rst_aw_addr", aw_addr, 0);
        chk("mid_rst_done", {done_valid, done_resp}, 0);
        chk("mid_rst_busy", busy, 0);
        data_valid = 0;
        @(negedge clock); reset = 1;
        @(posedge clock); #1;
        chk("post_rst_req_ready", req_ready, 1);
        burst(32'h4010, 5, 2, 2'b00);
        burst(32'h0FF8, 1, 2, 2'b00);
        burst(32'h5000, 2, 2, 2'b11);
        burst(32'h10000, 255, 2, 2'b10);
        for (int k = 0; k < 4; k++)
            burst($urandom, $urandom_range(0, 20), 2, 2'($urandom_range(0, 3)));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/axi4_write_burster.md
AXI4_WRITE_BURSTER -- requirements
Module: axi4_write_burster

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 32: AXI address width.
REQ-002 SHALL have parameter SIZE_BITS, default 3: AxSIZE width.
REQ-003 SHALL have parameter LEN_BITS, default 8: AxLEN width.
REQ-004 SHALL have parameter DATA_BITS, default 64: W data width, a power of two and at least 8.
REQ-005 SHALL have ports, in this order:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low.
- req_valid/req_ready  in/out  1  burst request handshake.
- req_addr  in  ADDR_BITS  burst byte address.
- req_len  in  LEN_BITS  beats minus 1.
- data_valid/data_ready  in/out  1  write-data stream handshake.
- data_bits  in  DATA_BITS  payload.
- aw_valid/aw_ready  out/in  1  AXI AW handshake.
- aw_addr  out  ADDR_BITS;  aw_size  out  SIZE_BITS;  aw_len  out  LEN_BITS;  aw_burst  out  2.
- w_valid/w_ready  out/in  1;  w_data  out  DATA_BITS;  w_strb  out  DATA_BITS/8;  w_last  out  1.
- b_valid/b_ready  in/out  1;  b_resp  in  2.
- done_valid  out  1  one-cycle completion pulse.
- done_resp  out  2  completion status.
- busy  out  1  high in any state other than IDLE.

Function
REQ-006 SHALL implement FSM states IDLE, ADDR, DATA, RESP, plus DRAIN when the configuration macro is defined.
REQ-007 IDLE: req_ready=1. On req fire, SHALL latch the address with its low log2(DATA_BITS/8) bits zeroed, latch req_len, clear the beat counter, and go to ADDR.
REQ-008 ADDR: aw_valid SHALL be registered and high, with aw_addr/aw_len from the latches.
- aw_size = log2(DATA_BITS/8); aw_burst = 2'b01 (INCR).
- Outputs held stable until aw fire, then go to DATA.
REQ-009 DATA: the W channel SHALL be a registered single-entry output buffer.
- data_ready = (!w_valid || w_ready) && (beats accepted <= latched len).
- On data fire: load w_data, set w_valid, w_strb all ones, increment the beat counter.
- w_last = 1 on the beat whose index equals the latched len.
REQ-010 When W fires with w_last=1, the FSM SHALL go to RESP; no further data is accepted.
REQ-011 Simultaneous w fire and data fire SHALL reload the buffer in the same cycle without a bubble.
REQ-012 RESP: b_ready=1. On b fire, the FSM SHALL pulse done_valid for exactly one cycle with done_resp=b_resp, then go to IDLE.
REQ-013 req_len=0 SHALL produce a single beat with w_last=1.
REQ-014 The beat counter SHALL be LEN_BITS+1 wide so that len=2^LEN_BITS-1 (256 beats) does not wrap.
REQ-015 aw_valid and w_valid SHALL never drop before their handshake completes.
REQ-016 A b_valid arriving outside RESP SHALL be ignored (b_ready=0).

Reset
REQ-017 Asserting reset (low) SHALL immediately force:
- state IDLE, counters 0;
- aw_valid, w_valid, w_last, done_valid, busy low;
- done_resp, w_data, aw_addr = 0.
REQ-018 Reset mid-burst SHALL abandon the burst; after release, req_ready=1 on the first clock edge.

Configuration
REQ-019 Macro AXI_WB_4K_CHECK_EN SHALL control the 4 KB boundary check.
- Defined: a request where (aligned_addr[11:0] + (len+1)*DATA_BITS/8) > 4096 goes IDLE->DRAIN with no AW issued.
- DRAIN: data_ready=1 for exactly len+1 beats, with no W traffic.
- DRAIN then pulses done_valid with done_resp=2'b10 and returns to IDLE.
- Undefined: no check, and the DRAIN state is absent.

Verification (DATA_BITS=64)
REQ-020 req addr=0x1000, len=3, aw/w_ready tied 1 -> one AW (len=3, size=3, burst=1), then 4 W beats with w_last on beat 4; b_resp=0 -> done_valid one cycle, done_resp=0.
REQ-021 len=0, addr=0x2004 -> aw_addr=0x2000, single beat with w_last=1.
REQ-022 w_ready toggling 1/0 every cycle, len=7 -> exactly 8 W beats, data order preserved, w_valid never drops unaccepted.
REQ-023 reset low during beat 2 of a len=7 burst -> all outputs at reset values the same cycle; next req completes normally.
REQ-024 with AXI_WB_4K_CHECK_EN, addr=0x0FF8, len=1 -> no AW, 2 data beats drained, done_resp=2'b10; without the macro, normal AW at 0x0FF8.
REQ-025 b_resp=2'b11 -> done_resp=2'b11; len=255 -> 256 beats, w_last only on the final beat.
